// File: rtl/ddc_fs4_cic.sv
// fs/4 quadrature mixer into a 3-stage CIC decimator per channel; a pair is strobed 6 cycles after a frame's last sample.
// Define DDC_OUT_SAT_EN to saturate (and flag) out-of-range results; otherwise they wrap to OUT_W bits.
module ddc_fs4_cic #(
   parameter int IN_W         = 10,
   parameter int OUT_W        = 12,
   parameter int MAX_DEC_LOG2 = 8
) (
   input  logic                    adc_clk,
   input  logic                    rst,
   input  logic [IN_W-1:0]         adc_data,
   input  logic                    adc_or,
   input  logic                    enable,
   input  logic [3:0]              dec_log2,
   input  logic [2:0]              gain,
   input  logic                    ovf_clr,
   output logic signed [OUT_W-1:0] i_out,
   output logic signed [OUT_W-1:0] q_out,
   output logic                    out_valid,
   output logic                    ovf
);
   localparam int X_W   = IN_W + 1;
   localparam int ACC_W = IN_W + 1 + 3*MAX_DEC_LOG2;
   localparam int SH_W  = $clog2(3*MAX_DEC_LOG2 + 8);
`ifdef DDC_OUT_SAT_EN
   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2**(OUT_W-1) - 1);
   localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
`endif

   logic                    enable_d;
   logic [3:0]              dec_r, dec_eff;
   logic [2:0]              gain_r;
   logic [1:0]              p, x_ph;
   logic [MAX_DEC_LOG2-1:0] cnt, cnt_max;
   logic                    frame_end;
   logic signed [X_W-1:0]   x_r;
   logic signed [X_W-1:0]   mix [2];
   logic [4:0]              last_sr;
   logic                    comb_vld;
   logic signed [ACC_W-1:0] int1 [2], int2 [2], int3 [2];
   logic signed [ACC_W-1:0] d1 [2], d2 [2], d3 [2];
   logic signed [ACC_W-1:0] c1 [2], c2 [2], c3 [2], c3_r [2];
   logic signed [ACC_W-1:0] shifted [2];
   logic signed [OUT_W-1:0] res [2];
   logic [SH_W-1:0]         dec3, g, sh;
   logic                    clip;

   // On the rising cycle of enable the new setting must already govern the first sample's frame count.
   always_comb begin
      dec_eff = dec_r;
      if (enable && !enable_d) begin
         if (dec_log2 == 4'd0)
            dec_eff = 4'd1;
         else if (int'(dec_log2) > MAX_DEC_LOG2)
            dec_eff = 4'(MAX_DEC_LOG2);
         else
            dec_eff = dec_log2;
      end
      cnt_max   = MAX_DEC_LOG2'((32'd1 << dec_eff) - 32'd1);
      frame_end = (cnt == cnt_max);
   end

   always_ff @(posedge adc_clk or negedge rst) begin
      if (!rst) begin
         enable_d <= 1'b0;
         dec_r    <= 4'd1;
         gain_r   <= '0;
      end else begin
         enable_d <= enable;
         if (enable && !enable_d) begin
            dec_r  <= dec_eff;
            gain_r <= gain;
         end
      end
   end

   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         c1[ch] = int3[ch] - d1[ch];
         c2[ch] = c1[ch] - d2[ch];
         c3[ch] = c2[ch] - d3[ch];
      end
   end

   // last_sr carries the frame-end tag alongside capture, mixer and the three integrator stages.
   always_ff @(posedge adc_clk or negedge rst) begin
      if (!rst) begin
         p <= '0; cnt <= '0; x_r <= '0; x_ph <= '0; last_sr <= '0; comb_vld <= 1'b0;
         for (int ch = 0; ch < 2; ch++) begin
            mix[ch]  <= '0; int1[ch] <= '0; int2[ch] <= '0; int3[ch] <= '0;
            d1[ch]   <= '0; d2[ch]   <= '0; d3[ch]   <= '0; c3_r[ch] <= '0;
         end
      end else if (!enable) begin
         p <= '0; cnt <= '0; x_r <= '0; x_ph <= '0; last_sr <= '0; comb_vld <= 1'b0;
         for (int ch = 0; ch < 2; ch++) begin
            mix[ch]  <= '0; int1[ch] <= '0; int2[ch] <= '0; int3[ch] <= '0;
            d1[ch]   <= '0; d2[ch]   <= '0; d3[ch]   <= '0; c3_r[ch] <= '0;
         end
      end else begin
         p        <= p + 2'd1;
         cnt      <= frame_end ? '0 : cnt + MAX_DEC_LOG2'(1);
         x_r      <= {{2{~adc_data[IN_W-1]}}, adc_data[IN_W-2:0]};
         x_ph     <= p;
         last_sr  <= {last_sr[3:0], frame_end};
         comb_vld <= last_sr[4];
         case (x_ph)
            2'd0:    begin mix[0] <= x_r;  mix[1] <= '0;   end
            2'd1:    begin mix[0] <= '0;   mix[1] <= -x_r; end
            2'd2:    begin mix[0] <= -x_r; mix[1] <= '0;   end
            default: begin mix[0] <= '0;   mix[1] <= x_r;  end
         endcase
         for (int ch = 0; ch < 2; ch++) begin
            int1[ch] <= int1[ch] + {{(ACC_W-X_W){mix[ch][X_W-1]}}, mix[ch]};
            int2[ch] <= int2[ch] + int1[ch];
            int3[ch] <= int3[ch] + int2[ch];
            if (last_sr[4]) begin
               d1[ch]   <= int3[ch];
               d2[ch]   <= c1[ch];
               d3[ch]   <= c2[ch];
               c3_r[ch] <= c3[ch];
            end
         end
      end
   end

   // Gain is applied by shifting right less, never by shifting left past the CIC growth.
   always_comb begin
      dec3 = SH_W'(3 * int'(dec_r));
      g    = (SH_W'(gain_r) > dec3) ? dec3 : SH_W'(gain_r);
      sh   = dec3 - g;
      clip = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
         shifted[ch] = c3_r[ch] >>> sh;
`ifdef DDC_OUT_SAT_EN
         if (shifted[ch] > OUT_MAX) begin
            res[ch] = OUT_MAX[OUT_W-1:0];
            clip    = 1'b1;
         end else if (shifted[ch] < OUT_MIN) begin
            res[ch] = OUT_MIN[OUT_W-1:0];
            clip    = 1'b1;
         end else begin
            res[ch] = OUT_W'(shifted[ch]);
         end
`else
         res[ch] = OUT_W'(shifted[ch]);
`endif
      end
   end

   always_ff @(posedge adc_clk or negedge rst) begin
      if (!rst) begin
         i_out     <= '0;
         q_out     <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= enable && comb_vld;
         if (enable && comb_vld) begin
            i_out <= res[0];
            q_out <= res[1];
         end
         if (enable && (adc_or || (comb_vld && clip)))
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end
endmodule
